// File: rtl/mic_sequencer.sv
// Mic-1 microsequencer.
// Holds the 512 x 36 control store, the microprogram counter (MPC) and the
// microinstruction register (MIR). It slices the MIR into the datapath
// control fields and computes the next microaddress from the MIR, the
// ALU N/Z outputs and the MBR.
module mic_sequencer #(
  parameter int unsigned ALU_CONTROL = 6,
  parameter int unsigned MPC_BITS    = 9,
  parameter int unsigned MIR_BITS    = 36,
  parameter logic [MPC_BITS-1:0] HALT_ADDR = 9'h1FF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   cs_we,
  input  logic [MPC_BITS-1:0]    cs_addr,
  input  logic [MIR_BITS-1:0]    cs_wdata,
  input  logic                   n,
  input  logic                   z,
  input  logic [MPC_BITS-2:0]    mbr,
  input  logic                   mem_wait,
  output logic [ALU_CONTROL-1:0] alu_control,
  output logic [1:0]             shift_ctrl,
  output logic [8:0]             c_enable,
  output logic [2:0]             mem_ctrl,
  output logic [3:0]             b_sel,
  output logic [MPC_BITS-1:0]    mpc,
  output logic                   n_flag,
  output logic                   z_flag,
  output logic                   halted
);

  // MIR field positions.
  localparam int unsigned NA_LSB   = 27;
  localparam int unsigned JMPC_BIT = 26;
  localparam int unsigned JAMN_BIT = 25;
  localparam int unsigned JAMZ_BIT = 24;
  localparam int unsigned CS_DEPTH = 1 << MPC_BITS;

  typedef enum logic [0:0] {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q;
  logic [MPC_BITS-1:0]   mpc_q;
  logic [MIR_BITS-1:0]   mir_q;
  logic                  n_flag_q;
  logic                  z_flag_q;
  logic                  halted_q;
  logic [MPC_BITS-1:0]   na_d;
  logic                  cs_wr_s;

  // Control store: no reset, so the microprogram survives a reset.
  logic [MIR_BITS-1:0]   cs_mem [CS_DEPTH];

  // Next microaddress: NEXT_ADDRESS, with the high bit ORed by the taken
  // JAMN/JAMZ condition and the low byte ORed with MBR on JMPC.
  function automatic logic [MPC_BITS-1:0] calc_next_addr(
    input logic [MIR_BITS-1:0] mir,
    input logic                n_in,
    input logic                z_in,
    input logic [MPC_BITS-2:0] mbr_in
  );
    logic [MPC_BITS-1:0] addr;
    addr = mir[NA_LSB +: MPC_BITS];
    addr[MPC_BITS-1] = addr[MPC_BITS-1]
                     | (mir[JAMN_BIT] & n_in)
                     | (mir[JAMZ_BIT] & z_in);
    if (mir[JMPC_BIT]) begin
      addr[MPC_BITS-2:0] = addr[MPC_BITS-2:0] | mbr_in;
    end else begin
      addr[MPC_BITS-2:0] = addr[MPC_BITS-2:0];
    end
    return addr;
  endfunction

  // Combinational next-address and store-write qualification.
  always_comb begin
    na_d    = calc_next_addr(mir_q, n, z, mbr);
    cs_wr_s = 1'b0;
    if (state_q == ST_HALT) begin
      cs_wr_s = cs_we;
    end else begin
      cs_wr_s = 1'b0;
    end
  end

  // Control store write port; writes are only accepted while halted.
  always_ff @(posedge clk) begin
    if (cs_wr_s) begin
      cs_mem[cs_addr] <= cs_wdata;
    end
  end

  // Sequencer FSM: loads MIR from the store, advances MPC, captures flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_HALT;
      mpc_q    <= {MPC_BITS{1'b0}};
      mir_q    <= {MIR_BITS{1'b0}};
      n_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      case (state_q)
        ST_HALT: begin
          // A write in the same cycle as start takes priority.
          if (start && !cs_we) begin
            state_q  <= ST_RUN;
            mpc_q    <= {MPC_BITS{1'b0}};
            mir_q    <= cs_mem[{MPC_BITS{1'b0}}];
            halted_q <= 1'b0;
          end else begin
            state_q  <= ST_HALT;
            mir_q    <= {MIR_BITS{1'b0}};
            halted_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!mem_wait) begin
            n_flag_q <= n;
            z_flag_q <= z;
            if (na_d == HALT_ADDR) begin
              // The word at the halt address is never executed.
              state_q  <= ST_HALT;
              mpc_q    <= HALT_ADDR;
              mir_q    <= {MIR_BITS{1'b0}};
              halted_q <= 1'b1;
            end else begin
              state_q  <= ST_RUN;
              mpc_q    <= na_d;
              mir_q    <= cs_mem[na_d];
              halted_q <= 1'b0;
            end
          end else begin
            // Stalled on memory: everything holds.
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_HALT;
          mpc_q    <= {MPC_BITS{1'b0}};
          mir_q    <= {MIR_BITS{1'b0}};
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // Field outputs are plain slices of registered state.
  assign shift_ctrl  = mir_q[23:22];
  assign alu_control = mir_q[16 +: ALU_CONTROL];
  assign c_enable    = mir_q[15:7];
  assign mem_ctrl    = mir_q[6:4];
  assign b_sel       = mir_q[3:0];
  assign mpc         = mpc_q;
  assign n_flag      = n_flag_q;
  assign z_flag      = z_flag_q;
  assign halted      = halted_q;

endmodule
